if_fetch_unit: RTL and testbench

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

---
 rtl/cpu_pkg.sv | 16 +
 rtl/fetch_fifo.sv | 59 +++++
 rtl/if_fetch_unit.sv | 105 ++++++++++
 tb/tb_if_fetch_unit.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared fetch-stage types and constants: FSM state encoding, reset PC and instruction width.
package cpu_pkg;
    localparam int          INSTR_WIDTH      = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

    // Sequential fetch step; the 32-bit add wraps 32'hFFFF_FFFC to 0.
    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction
endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer holding (pc, instr) pairs; flush wins over push and pop.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    input  logic [31:0]            push_pc_i,
    input  logic [INSTR_WIDTH-1:0] push_instr_i,
    output logic [31:0]            head_pc_o,
    output logic [INSTR_WIDTH-1:0] head_instr_o,
    output logic [2:0]             count_o,
    output logic                   empty_o
);
    localparam int         PTR_W   = $clog2(DEPTH);
    localparam logic [2:0] DEPTH_C = 3'(DEPTH);

    logic [31:0]            pc_mem_q    [DEPTH];
    logic [INSTR_WIDTH-1:0] instr_mem_q [DEPTH];
    logic [PTR_W-1:0]       rd_ptr_q, wr_ptr_q;
    logic [2:0]             count_q;
    logic                   do_push, do_pop;

    assign do_push = push_i && !flush_i && (count_q != DEPTH_C);
    assign do_pop  = pop_i && !flush_i && (count_q != 3'd0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= 3'd0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= 3'd0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + {2'b00, do_push} - {2'b00, do_pop};
        end
    end

    // Storage needs no reset: entries are only visible while count is non-zero.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            pc_mem_q[wr_ptr_q]    <= push_pc_i;
            instr_mem_q[wr_ptr_q] <= push_instr_i;
        end
    end

    assign head_pc_o    = pc_mem_q[rd_ptr_q];
    assign head_instr_o = instr_mem_q[rd_ptr_q];
    assign count_o      = count_q;
    assign empty_o      = (count_q == 3'd0);
endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: one outstanding imem request, prefetch buffer, redirect/discard handling.
// Define IF_FETCH_BYPASS_EN to forward an acked word straight to the outputs when the buffer is empty.
module if_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        stall_i,
    output logic        valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [1:0]  fsm_state_o
);
    localparam logic [2:0] DEPTH_C = 3'(DEPTH);

    fetch_state_t state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  disc_addr_q, disc_addr_d;
    logic [31:0]  head_pc, head_instr;
    logic [2:0]   count, count_next;
    logic         fifo_empty, fill, bypass_hit, pop, pop_fifo, push;

    // A completion in REQ keeps its word unless a redirect arrives in the same cycle.
    assign fill = (state_q == REQ) && imem_ack_i && !redirect_i;
`ifdef IF_FETCH_BYPASS_EN
    assign bypass_hit = fill && fifo_empty;
`else
    assign bypass_hit = 1'b0;
`endif
    assign valid_o    = !fifo_empty || bypass_hit;
    assign pop        = valid_o && !stall_i && !redirect_i;
    assign pop_fifo   = pop && !bypass_hit;
    assign push       = fill && !(bypass_hit && pop);
    assign count_next = redirect_i ? 3'd0 : count + {2'b00, push} - {2'b00, pop_fifo};

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .push_i       (push),
        .pop_i        (pop_fifo),
        .flush_i      (redirect_i),
        .push_pc_i    (fetch_pc_q),
        .push_instr_i (imem_rdata_i),
        .head_pc_o    (head_pc),
        .head_instr_o (head_instr),
        .count_o      (count),
        .empty_o      (fifo_empty)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i && !redirect_i && count < DEPTH_C) state_d = REQ;
            REQ: begin
                if (imem_ack_i)      state_d = (start_i && count_next < DEPTH_C) ? REQ : IDLE;
                else if (redirect_i) state_d = DISCARD;
            end
            DISCARD: if (imem_ack_i) state_d = REQ;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        imem_req_o  = (state_q != IDLE);
        imem_addr_o = (state_q == DISCARD) ? disc_addr_q : fetch_pc_q;
    end

    // The in-flight address is parked in disc_addr_q so fetch_pc can take the redirect target.
    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        disc_addr_d = disc_addr_q;
        if (redirect_i)  fetch_pc_d = {redirect_pc_i[31:2], 2'b00};
        else if (fill)   fetch_pc_d = next_pc(fetch_pc_q);
        if (state_q == REQ && !imem_ack_i && redirect_i) disc_addr_d = fetch_pc_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetch_pc_q  <= RESET_PC;
            disc_addr_q <= RESET_PC;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            disc_addr_q <= disc_addr_d;
        end
    end

    assign instr_o     = bypass_hit ? imem_rdata_i : (fifo_empty ? 32'd0 : head_instr);
    assign pc_o        = bypass_hit ? fetch_pc_q   : (fifo_empty ? 32'd0 : head_pc);
    assign fsm_state_o = state_q;
endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios plus randomized traffic against a queue model.
module tb_if_fetch_unit;
    import cpu_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] KEY      = 32'hA5A5_0000;
`ifdef IF_FETCH_BYPASS_EN
    localparam int FIRST_VALID = 1;
    localparam bit BYPASS      = 1'b1;
`else
    localparam int FIRST_VALID = 2;
    localparam bit BYPASS      = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i = 1'b0;
    logic [31:0] imem_rdata_i = 32'd0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'd0;
    logic        stall_i = 1'b0;
    logic        valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic [1:0]  fsm_state_o;

    if_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_rdata_i  (imem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .stall_i       (stall_i),
        .valid_o       (valid_o),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .fsm_state_o   (fsm_state_o)
    );

    // ---------------- clock ----------------
    always #5 clk_i = ~clk_i;

    // ---------------- scoreboard state ----------------
    int          n_pass = 0;
    int          n_total = 0;
    int          ack_pct = 100;
    logic [63:0] exp_q[$];
    logic [31:0] m_fetch = RESET_PC;
    logic [31:0] m_drop_addr = 32'd0;
    bit          m_drop = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk_i);
        #1;
        redirect_i   = 1'b0;
        imem_ack_i   = imem_req_o && ($urandom_range(0, 99) < ack_pct);
        imem_rdata_i = imem_addr_o ^ KEY;
    endtask

    task automatic apply_reset();
        rst_i = 1'b1; start_i = 1'b0; stall_i = 1'b0; redirect_i = 1'b0;
        redirect_pc_i = 32'd0; imem_ack_i = 1'b0; imem_rdata_i = 32'd0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    task automatic wait_req(input int budget);
        int n;
        n = 0;
        while (!imem_req_o && n < budget) begin
            step();
            n++;
        end
        check("wait_req_timeout", 32'(imem_req_o), 32'd1);
    endtask

    // ---------------- monitor + reference model ----------------
    // The model tracks the word stream the fetch stage owes downstream: acked words in
    // address order, cleared by redirects, with the in-flight word dropped after a redirect.
    int          sz;
    bit          done, kept, exp_valid, byp_taken;
    logic [63:0] word, head;

    always @(negedge clk_i) begin
        if (rst_i) begin
            exp_q.delete();
            m_fetch = RESET_PC;
            m_drop  = 1'b0;
        end else begin
            sz        = exp_q.size();
            done      = imem_req_o && imem_ack_i;
            kept      = done && !m_drop && !redirect_i;
            word      = {imem_addr_o, imem_rdata_i};
            byp_taken = 1'b0;
            if (imem_req_o) check("req_addr", imem_addr_o, m_drop ? m_drop_addr : m_fetch);
            exp_valid = (sz > 0) || (BYPASS && kept && sz == 0);
            check("valid", 32'(valid_o), 32'(exp_valid));
            if (valid_o && exp_valid) begin
                head = (sz > 0) ? exp_q[0] : word;
                check("pc", pc_o, head[63:32]);
                check("instr", instr_o, head[31:0]);
            end else if (!valid_o) begin
                check("idle_pc", pc_o, 32'd0);
                check("idle_instr", instr_o, 32'd0);
            end
            if (exp_valid && !stall_i && !redirect_i) begin
                if (sz > 0) void'(exp_q.pop_front());
                else        byp_taken = 1'b1;
            end
            if (kept && !byp_taken) exp_q.push_back(word);
            if (done) begin
                if (m_drop)           m_drop = 1'b0;
                else if (!redirect_i) m_fetch = m_fetch + 32'd4;
            end else if (imem_req_o && redirect_i && !m_drop) begin
                m_drop      = 1'b1;
                m_drop_addr = m_fetch;
            end
            if (redirect_i) begin
                exp_q.delete();
                m_fetch = redirect_pc_i;
            end
            n_total++;
            if (exp_q.size() <= DEPTH) n_pass++;
            else $display("FAIL over_fetch: got %0d buffered expected at most %0d", exp_q.size(), DEPTH);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        // Reset values and streaming at one instruction per cycle
        apply_reset();
        #1;
        check("rst_req", 32'(imem_req_o), 32'd0);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_instr", instr_o, 32'd0);
        check("rst_pc", pc_o, 32'd0);
        check("rst_state", 32'(fsm_state_o), 32'(IDLE));
        ack_pct = 100;
        start_i = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            #1;
            check("stream_req", 32'(imem_req_o), 32'd1);
            if (k >= FIRST_VALID) begin
                check("stream_valid", 32'(valid_o), 32'd1);
                check("stream_pc", pc_o, RESET_PC + 32'(4 * (k - FIRST_VALID)));
                check("stream_instr", instr_o, (RESET_PC + 32'(4 * (k - FIRST_VALID))) ^ KEY);
            end
        end

        // Held stall fills exactly DEPTH entries and stops requesting
        apply_reset();
        ack_pct = 100;
        stall_i = 1'b1;
        start_i = 1'b1;
        repeat (10) step();
        #1;
        check("stall_req", 32'(imem_req_o), 32'd0);
        check("stall_fill", 32'(exp_q.size()), 32'(DEPTH));
        check("stall_head", pc_o, RESET_PC);
        stall_i = 1'b0;
        repeat (20) step();
        #1;
        check("stall_resume_req", 32'(imem_req_o), 32'd1);

        // Redirect during a waiting request: old word dropped via DISCARD
        apply_reset();
        ack_pct = 0;
        redirect_i = 1'b1;
        redirect_pc_i = 32'h10;
        step();
        start_i = 1'b1;
        step();
        #1;
        check("disc_first_addr", imem_addr_o, 32'h10);
        redirect_i = 1'b1;
        redirect_pc_i = 32'h100;
        step();
        #1;
        check("disc_state", 32'(fsm_state_o), 32'(DISCARD));
        check("disc_hold_addr", imem_addr_o, 32'h10);
        step();
        imem_ack_i = 1'b1;
        step();
        #1;
        check("disc_next_addr", imem_addr_o, 32'h100);
        check("disc_next_req", 32'(imem_req_o), 32'd1);
        ack_pct = 100;
        repeat (6) step();

        // Redirect in the same cycle as an ack: no DISCARD, empty buffer
        apply_reset();
        ack_pct = 100;
        start_i = 1'b1;
        repeat (4) step();
        #1;
        check("samecyc_ack", 32'(imem_req_o && imem_ack_i), 32'd1);
        redirect_i = 1'b1;
        redirect_pc_i = 32'h40;
        step();
        imem_ack_i = 1'b0;
        #1;
        check("samecyc_state", 32'(fsm_state_o), 32'(REQ));
        check("samecyc_valid", 32'(valid_o), 32'd0);
        check("samecyc_addr", imem_addr_o, 32'h40);
        step();
        redirect_i = 1'b1;
        redirect_pc_i = 32'hFFFF_FFF8;
        repeat (8) step();

        // Reset pulsed mid-request with an ack during reset
        apply_reset();
        ack_pct = 0;
        start_i = 1'b1;
        wait_req(5);
        step();
        imem_ack_i = 1'b1;
        rst_i = 1'b1;
        #1;
        check("midrst_req", 32'(imem_req_o), 32'd0);
        check("midrst_valid", 32'(valid_o), 32'd0);
        check("midrst_instr", instr_o, 32'd0);
        check("midrst_pc", pc_o, 32'd0);
        step();
        imem_ack_i = 1'b1;
        step();
        rst_i = 1'b0;
        imem_ack_i = 1'b0;
        ack_pct = 100;
        wait_req(5);
        #1;
        check("midrst_first_addr", imem_addr_o, RESET_PC);
        repeat (4) step();

`ifdef IF_FETCH_BYPASS_EN
        // Bypass: empty buffer, ack shows on the outputs in the same cycle
        apply_reset();
        ack_pct = 0;
        start_i = 1'b1;
        wait_req(5);
        imem_ack_i = 1'b1;
        imem_rdata_i = 32'h2002_0005;
        #1;
        check("bypass_valid", 32'(valid_o), 32'd1);
        check("bypass_instr", instr_o, 32'h2002_0005);
        check("bypass_pc", pc_o, RESET_PC);
        ack_pct = 100;
        repeat (4) step();
`endif

        // Randomized traffic
        apply_reset();
        for (int c = 0; c < 800; c++) begin
            step();
            ack_pct = $urandom_range(20, 100);
            imem_ack_i = imem_req_o && ($urandom_range(0, 99) < ack_pct);
            start_i = ($urandom_range(0, 99) < 90);
            stall_i = ($urandom_range(0, 99) < 30);
            if ($urandom_range(0, 99) < 4) begin
                redirect_i = 1'b1;
                redirect_pc_i = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8
                                                            : {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            end
        end

        // Drain: every owed word must be delivered
        start_i = 1'b0;
        stall_i = 1'b0;
        ack_pct = 100;
        repeat (12) step();
        #1;
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        check("drain_valid", 32'(valid_o), 32'd0);
        check("drain_idle", 32'(imem_req_o), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
